// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART transmit FIFO slice.
//   PAYLOAD_BITS_DEF : default data width per FIFO entry
//   drain_state_e    : drain state machine encoding (IDLE / SENT / DRAIN)
package uart_pkg;

  localparam int PAYLOAD_BITS_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SENT  = 2'd1,
    DRAIN = 2'd2
  } drain_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem -- DEPTH x PAYLOAD_BITS register array for the UART TX FIFO.
// One synchronous write port, one asynchronous (combinational) read port.
// No reset: contents are only ever read at addresses that were written since
// the owning FIFO last cleared its pointers.
//   clk     : system clock (rising edge)
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address
//   rd_data : read data, combinational from rd_addr
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int PAYLOAD_BITS = PAYLOAD_BITS_DEF,
  parameter int DEPTH        = 16,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [PAYLOAD_BITS-1:0] wr_data,
  input  logic [AW-1:0]           rd_addr,
  output logic [PAYLOAD_BITS-1:0] rd_data
);

  logic [PAYLOAD_BITS-1:0] mem_r [DEPTH];

  // Storage write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo -- byte FIFO that feeds a UART transmitter one strobe per
// transmitter busy period.
//   clk          : system clock (rising edge)
//   reset        : synchronous active-high reset
//   wr_valid     : producer presents a byte
//   wr_data      : byte to enqueue
//   wr_ready     : FIFO can accept a byte (registered, = count != DEPTH)
//   uart_tx_en   : one-cycle send strobe to the transmitter (registered)
//   uart_tx_data : byte for the transmitter, held until the next pop
//   uart_tx_busy : transmitter busy, rises the cycle after uart_tx_en is sampled
//   empty        : FIFO holds no entries (registered)
// Optional (macro UART_TX_FIFO_STATUS_EN):
//   level        : current entry count
//   overflow     : sticky, set on a write attempt while not ready; reset clears
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int PAYLOAD_BITS = PAYLOAD_BITS_DEF,
  parameter int DEPTH        = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_valid,
  input  logic [PAYLOAD_BITS-1:0] wr_data,
  output logic                    wr_ready,
  output logic                    uart_tx_en,
  output logic [PAYLOAD_BITS-1:0] uart_tx_data,
  input  logic                    uart_tx_busy,
  output logic                    empty
`ifdef UART_TX_FIFO_STATUS_EN
  ,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] ZERO_COUNT = {CW{1'b0}};

  drain_state_e            state_r;
  drain_state_e            state_s;
  logic [AW-1:0]           wr_ptr_r;
  logic [AW-1:0]           rd_ptr_r;
  logic [CW-1:0]           count_r;
  logic [CW-1:0]           count_s;
  logic                    wr_ready_r;
  logic                    empty_r;
  logic                    tx_en_r;
  logic [PAYLOAD_BITS-1:0] tx_data_r;
  logic                    wr_fire_s;
  logic                    pop_s;
  logic                    mem_we_s;
  logic [PAYLOAD_BITS-1:0] rd_data_s;

  // wr_ready_r already reflects the pre-edge count, so a pop in the same
  // cycle can never open a slot for a write while full.
  assign wr_fire_s = wr_valid & wr_ready_r;
  assign mem_we_s  = wr_fire_s & ~reset;

  uart_fifo_mem #(
    .PAYLOAD_BITS (PAYLOAD_BITS),
    .DEPTH        (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (mem_we_s),
    .wr_addr (wr_ptr_r),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_r),
    .rd_data (rd_data_s)
  );

  // Drain FSM next state and pop decision. Pops only look at the registered
  // count, so a byte written this cycle cannot be popped until the next one.
  always_comb begin
    state_s = state_r;
    pop_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if ((count_r != ZERO_COUNT) && !uart_tx_busy) begin
          pop_s   = 1'b1;
          state_s = SENT;
        end else begin
          state_s = IDLE;
        end
      end
      SENT: begin
        if (uart_tx_busy) begin
          state_s = DRAIN;
        end else begin
          state_s = SENT;
        end
      end
      DRAIN: begin
        if (!uart_tx_busy) begin
          state_s = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Next occupancy: simultaneous write and pop leave the count unchanged.
  always_comb begin
    count_s = count_r;
    case ({wr_fire_s, pop_s})
      2'b10:   count_s = count_r + CW'(1'b1);
      2'b01:   count_s = count_r - CW'(1'b1);
      default: count_s = count_r;
    endcase
  end

  // State, pointers, occupancy and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= ZERO_COUNT;
      wr_ready_r <= 1'b0;
      empty_r    <= 1'b1;
      tx_en_r    <= 1'b0;
      tx_data_r  <= {PAYLOAD_BITS{1'b0}};
    end else begin
      state_r    <= state_s;
      count_r    <= count_s;
      wr_ready_r <= (count_s != FULL_COUNT);
      empty_r    <= (count_s == ZERO_COUNT);
      tx_en_r    <= pop_s;
      if (wr_fire_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r  <= rd_ptr_r + AW'(1'b1);
        tx_data_r <= rd_data_s;
      end
    end
  end

  assign wr_ready     = wr_ready_r;
  assign empty        = empty_r;
  assign uart_tx_en   = tx_en_r;
  assign uart_tx_data = tx_data_r;

`ifdef UART_TX_FIFO_STATUS_EN
  logic overflow_r;

  // Sticky overflow: any refused write attempt sets it until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r | (wr_valid & ~wr_ready_r);
    end
  end

  assign level    = count_r;
  assign overflow = overflow_r;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo -- self-checking bench for uart_tx_fifo.
// A queue-based reference model predicts every output each cycle; a simple
// transmitter model drives uart_tx_busy. Directed scenarios pin literal values,
// then a randomized phase runs against the model.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       uart_tx_en;
  logic [7:0] uart_tx_data;
  logic       uart_tx_busy;
  logic       empty;
`ifdef UART_TX_FIFO_STATUS_EN
  logic [4:0] level;
  logic       overflow;
`endif

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [7:0] m_q[$];
  logic       m_ready, m_en, m_empty, m_ovf;
  logic [7:0] m_data;
  int         m_phase;   // 0 free to send, 1 waiting for busy to rise, 2 waiting for busy to fall
  bit         m_valid = 1'b0;

  // transmitter model
  int  busy_left  = 0;
  int  busy_len   = 10;
  bit  start_next = 1'b0;
  bit  force_busy = 1'b0;

  logic [7:0] dut_log[$];

  uart_tx_fifo dut (
    .clk          (clk),
    .reset        (reset),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .uart_tx_en   (uart_tx_en),
    .uart_tx_data (uart_tx_data),
    .uart_tx_busy (uart_tx_busy),
    .empty        (empty)
`ifdef UART_TX_FIFO_STATUS_EN
    ,
    .level        (level),
    .overflow     (overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance the model by one rising edge using the inputs the DUT sees.
  task automatic model_step();
    bit acc;
    bit pop;
    if (reset) begin
      m_q.delete();
      m_ready = 1'b0; m_en = 1'b0; m_data = 8'h00; m_empty = 1'b1;
      m_phase = 0;    m_ovf = 1'b0; m_valid = 1'b1;
    end else if (m_valid) begin
      acc = wr_valid && m_ready;
      if (wr_valid && !m_ready) m_ovf = 1'b1;
      pop = (m_phase == 0) && (m_q.size() > 0) && !uart_tx_busy;
      if (m_phase == 1 && uart_tx_busy) m_phase = 2;
      else if (m_phase == 2 && !uart_tx_busy) m_phase = 0;
      m_en = pop;
      if (pop) begin
        m_data  = m_q.pop_front();
        m_phase = 1;
      end
      if (acc) m_q.push_back(wr_data);
      m_ready = (m_q.size() != DEPTH);
      m_empty = (m_q.size() == 0);
    end
  endtask

  task automatic compare();
    if (m_valid) begin
      check("wr_ready", 32'(wr_ready), 32'(m_ready));
      check("uart_tx_en", 32'(uart_tx_en), 32'(m_en));
      check("uart_tx_data", 32'(uart_tx_data), 32'(m_data));
      check("empty", 32'(empty), 32'(m_empty));
`ifdef UART_TX_FIFO_STATUS_EN
      check("level", 32'(level), 32'(m_q.size()));
      check("overflow", 32'(overflow), 32'(m_ovf));
`endif
    end
    if (uart_tx_en === 1'b1) begin
      dut_log.push_back(uart_tx_data);
      // a strobe must only come from an idle transmitter, never back-to-back
      check("strobe_in_busy", 32'({uart_tx_busy, start_next}), 32'd0);
    end
  endtask

  // Transmitter: busy rises the cycle after the strobe is sampled.
  task automatic tx_model();
    if (busy_left > 0) busy_left--;
    if (start_next) begin
      busy_left  = busy_len;
      start_next = 1'b0;
    end
    if (uart_tx_en === 1'b1) start_next = 1'b1;
    uart_tx_busy = force_busy || (busy_left > 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
    tx_model();
  endtask

  initial begin
    reset = 1'b1; wr_valid = 1'b0; wr_data = 8'h00; uart_tx_busy = 1'b0;
    step();
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_tx_en", 32'(uart_tx_en), 32'd0);
    check("rst_tx_data", 32'(uart_tx_data), 32'd0);
    step();
    reset = 1'b0;
    step();
    check("ready_after_reset", 32'(wr_ready), 32'd1);

    // single byte into an empty FIFO, transmitter idle
    wr_valid = 1'b1; wr_data = 8'hA5;
    step();
    wr_valid = 1'b0;
    check("a5_no_bypass", 32'(uart_tx_en), 32'd0);
    check("a5_queued", 32'(empty), 32'd0);
    step();
    check("a5_en", 32'(uart_tx_en), 32'd1);
    check("a5_data", 32'(uart_tx_data), 32'hA5);
    check("a5_empty", 32'(empty), 32'd1);
    step();
    check("a5_single_pulse", 32'(uart_tx_en), 32'd0);
    check("a5_data_held", 32'(uart_tx_data), 32'hA5);
    repeat (15) step();

    // fill to full with the transmitter held busy
    force_busy = 1'b1; uart_tx_busy = 1'b1;
    dut_log.delete();
    for (int i = 0; i < 16; i++) begin
      wr_valid = 1'b1; wr_data = 8'(i);
      step();
    end
    check("full_not_ready", 32'(wr_ready), 32'd0);
    check("full_no_strobe", 32'(dut_log.size()), 32'd0);
`ifdef UART_TX_FIFO_STATUS_EN
    check("full_level", 32'(level), 32'd16);
`endif

    // busy drops: pop and refused write in the same cycle
    force_busy = 1'b0; uart_tx_busy = 1'b0;
    wr_valid = 1'b1; wr_data = 8'hEE;
    step();
    wr_valid = 1'b0;
    check("pop_full_en", 32'(uart_tx_en), 32'd1);
    check("pop_full_data", 32'(uart_tx_data), 32'h00);
    check("ready_after_pop", 32'(wr_ready), 32'd1);
`ifdef UART_TX_FIFO_STATUS_EN
    check("level_after_pop", 32'(level), 32'd15);
    check("overflow_set", 32'(overflow), 32'd1);
`endif
    repeat (16 * 14) step();
    check("drain_count", 32'(dut_log.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < dut_log.size()) check("drain_order", 32'(dut_log[i]), 32'(i));
    end
    check("drained_empty", 32'(empty), 32'd1);
`ifdef UART_TX_FIFO_STATUS_EN
    check("overflow_sticky", 32'(overflow), 32'd1);
`endif

    // reset while draining with 5 bytes still queued
    for (int i = 0; i < 6; i++) begin
      wr_valid = 1'b1; wr_data = 8'(8'h30 + i);
      step();
    end
    wr_valid = 1'b0;
    check("pre_reset_busy", 32'(uart_tx_busy), 32'd1);
    check("pre_reset_not_empty", 32'(empty), 32'd0);
    reset = 1'b1;
    step();
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_en", 32'(uart_tx_en), 32'd0);
    check("mid_rst_ready", 32'(wr_ready), 32'd0);
    reset = 1'b0;
    dut_log.delete();
    repeat (40) step();
    check("no_stale_byte", 32'(dut_log.size()), 32'd0);
    check("post_rst_ready", 32'(wr_ready), 32'd1);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      busy_len = int'($urandom_range(1, 10));
      reset    = ($urandom_range(0, 399) == 0);
      wr_valid = ($urandom_range(0, 99) < ((c / 500) % 2 == 0 ? 70 : 15));
      wr_data  = 8'($urandom);
      step();
    end
    reset = 1'b0; wr_valid = 1'b0;
    repeat (20 * 14) step();
    check("final_empty", 32'(empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have parameter PAYLOAD_BITS, default 8, giving the data width per entry.
REQ-002 The block SHALL have parameter DEPTH, default 16, giving the FIFO entry count; it SHALL be a power of two and at least 2.
REQ-003 Port clk, input, 1 bit: the single system clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port wr_valid, input, 1 bit: the producer presents a byte.
REQ-006 Port wr_data, input, PAYLOAD_BITS bits: the byte to enqueue.
REQ-007 Port wr_ready, output, 1 bit: the FIFO can accept a byte.
REQ-008 Port uart_tx_en, output, 1 bit: single-cycle send strobe to the downstream transmitter.
REQ-009 Port uart_tx_data, output, PAYLOAD_BITS bits: the byte for the transmitter.
REQ-010 Port uart_tx_busy, input, 1 bit: the downstream transmitter is busy; it rises the cycle after uart_tx_en is sampled.
REQ-011 Port empty, output, 1 bit: the FIFO holds no entries.

Function
REQ-012 A write SHALL be accepted on a rising edge when wr_valid and wr_ready are both 1.
REQ-013 wr_ready SHALL equal (count != DEPTH), using the count registered before the edge; a pop in the same cycle SHALL NOT admit a write while full.
REQ-014 count SHALL be $clog2(DEPTH)+1 bits wide; read and write pointers SHALL be $clog2(DEPTH) bits wide and wrap naturally.
REQ-015 A simultaneous write and pop SHALL leave count unchanged and keep both data items intact.
REQ-016 The drain state machine SHALL have states IDLE, SENT and DRAIN.
REQ-017 IDLE: when count != 0 and uart_tx_busy == 0, the block SHALL pop the head entry, register it on uart_tx_data, set uart_tx_en to 1, and go to SENT.
REQ-018 SENT: uart_tx_en SHALL be 0; on uart_tx_busy == 1 the machine SHALL go to DRAIN.
REQ-019 DRAIN: on uart_tx_busy == 0 the machine SHALL go to IDLE.
REQ-020 uart_tx_en SHALL be high for exactly one cycle per popped byte, and never twice within one transmitter busy period.
REQ-021 Latency SHALL be as follows: a byte written into an empty FIFO at edge N, with the transmitter idle, SHALL see uart_tx_en high after edge N+1.
REQ-022 There SHALL be no bypass path: a write to an empty FIFO SHALL NOT be popped in the same cycle.
REQ-023 uart_tx_data SHALL hold its value until the next pop.
REQ-024 Bytes SHALL leave in strict write order, with no loss or duplication.

Reset
REQ-025 While reset is high, the block SHALL drive wr_ready=0, uart_tx_en=0, uart_tx_data=0 and empty=1, and SHALL set state to IDLE, pointers to 0 and count to 0.
REQ-026 When reset is asserted mid-operation, all queued bytes SHALL be discarded and any pending uart_tx_en SHALL be cleared on that edge.
REQ-027 wr_ready SHALL rise on the first cycle after reset deasserts.

Configuration
REQ-028 The macro UART_TX_FIFO_STATUS_EN, when defined, SHALL add output level (width $clog2(DEPTH)+1), equal to count.
REQ-029 With UART_TX_FIFO_STATUS_EN defined, the block SHALL also add output overflow (1 bit): a sticky flag set when wr_valid is 1 and wr_ready is 0, and cleared only by reset.
REQ-030 Without UART_TX_FIFO_STATUS_EN, neither level nor overflow SHALL exist, and the remaining behaviour SHALL be identical.

Structure
REQ-031 A shared package uart_pkg SHALL hold the state enum (IDLE/SENT/DRAIN) and the default PAYLOAD_BITS constant.
REQ-032 Storage SHALL be a sub-module named uart_fifo_mem: a DEPTH x PAYLOAD_BITS register array with one write port and an asynchronous read port.
REQ-033 Control and pointers SHALL reside in uart_tx_fifo.

Verification
REQ-034 Scenario: write 0xA5 to an empty FIFO with uart_tx_busy=0 -> uart_tx_en high one cycle later with uart_tx_data=0xA5, and empty=1 afterwards.
REQ-035 Scenario: write 16 bytes 0x00..0x0F while busy is held at 1 -> wr_ready=0 after the 16th write; after busy drops, the bytes go out in order 0x00..0x0F.
REQ-036 Scenario: a transmitter model with busy high for 10 cycles after each strobe -> exactly one uart_tx_en pulse per busy period, with no pulse during SENT or DRAIN.
REQ-037 Scenario: FIFO full, then a pop and a write attempt in the same cycle -> the write is rejected, and the next cycle wr_ready=1 with count=15.
REQ-038 Scenario: reset asserted with 5 entries queued while in DRAIN -> next cycle empty=1, uart_tx_en=0, state IDLE, and no stale byte is sent after reset.
REQ-039 Scenario (UART_TX_FIFO_STATUS_EN defined): a write attempt when full -> overflow=1, level=16, and overflow stays 1 after draining until reset.
